// File: rtl/convertidor_bin_bcd_barrido.sv
// Binary to BCD double-dabble (ANCHO_BIN+1 cycles, inicio ignored while ocupado) plus continuous digit scan.
// Registered anodo/WXYZ; define SUPRIME_CEROS_EN to blank leading-zero digits.
module convertidor_bin_bcd_barrido #(
  parameter int ANCHO_BIN   = 8,
  parameter int DIGITOS     = 3,
  parameter int DIV_BARRIDO = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [ANCHO_BIN-1:0]   dato,
  output logic                   ocupado,
  output logic                   listo,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   W,
  output logic                   X,
  output logic                   Y,
  output logic                   Z,
  output logic [DIGITOS-1:0]     anodo
);

  localparam int AB = 4 * DIGITOS;
  localparam int CW = $clog2(ANCHO_BIN + 1);
  localparam int PW = (DIV_BARRIDO > 1) ? $clog2(DIV_BARRIDO) : 1;
  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam logic [CW-1:0] ULTIMO  = CW'(ANCHO_BIN - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV_BARRIDO - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITOS - 1);

  typedef enum logic [1:0] {REPOSO, DESPLAZA, FIN} estado_t;

  estado_t              estado, estado_sig;
  logic                 cargar, desplazar, terminar;
  logic [AB-1:0]        scratch, scratch_aj;
  logic [ANCHO_BIN-1:0] sreg;
  logic [CW-1:0]        cuenta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    cargar     = 1'b0;
    desplazar  = 1'b0;
    terminar   = 1'b0;
    unique case (estado)
      REPOSO: begin
        if (inicio) begin
          cargar     = 1'b1;
          estado_sig = DESPLAZA;
        end
      end
      DESPLAZA: begin
        desplazar = 1'b1;
        if (cuenta == ULTIMO) estado_sig = FIN;
      end
      FIN: begin
        terminar   = 1'b1;
        estado_sig = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Add-3 correction is applied before the shift so each digit stays within 0..9.
  always_comb begin
    scratch_aj = scratch;
    for (int d = 0; d < DIGITOS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) scratch_aj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      scratch <= '0;
      cuenta  <= '0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
      bcd     <= '0;
    end else begin
      listo <= terminar;
      if (cargar) begin
        sreg    <= dato;
        scratch <= '0;
        cuenta  <= '0;
        ocupado <= 1'b1;
      end else if (desplazar) begin
        {scratch, sreg} <= {scratch_aj[AB-2:0], sreg, 1'b0};
        cuenta          <= cuenta + CW'(1);
      end
      if (terminar) begin
        bcd     <= scratch;
        ocupado <= 1'b0;
      end
    end
  end

  logic [PW-1:0]      pre;
  logic [IW-1:0]      idx, idx_sig;
  logic [DIGITOS-1:0] anodo_sig;
  logic [3:0]         nib_sig;

  always_comb begin
    idx_sig = idx;
    if (pre == PRE_MAX) idx_sig = (idx == IDX_MAX) ? '0 : idx + IW'(1);
    nib_sig   = 4'd0;
    anodo_sig = '1;
    for (int d = 0; d < DIGITOS; d++) begin
      if (idx_sig == IW'(d)) begin
        nib_sig      = bcd[4*d +: 4];
        anodo_sig[d] = 1'b0;
      end
    end
`ifdef SUPRIME_CEROS_EN
    // Walking down from the top, a slot goes dark while every digit at or above it is zero.
    begin
      logic ceros;
      ceros = 1'b1;
      for (int d = DIGITOS - 1; d > 0; d--) begin
        if (bcd[4*d +: 4] != 4'd0) ceros = 1'b0;
        if ((idx_sig == IW'(d)) && ceros) anodo_sig = '1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre          <= '0;
      idx          <= '0;
      anodo        <= ~DIGITOS'(1);
      {W, X, Y, Z} <= 4'd0;
    end else begin
      pre          <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
      idx          <= idx_sig;
      anodo        <= anodo_sig;
      {W, X, Y, Z} <= nib_sig;
    end
  end

endmodule
